quad_decoder: RTL and testbench



---
 rtl/quad_decoder_pkg.sv | 38 +++
 rtl/quad_decoder_debounce.sv | 37 +++
 rtl/quad_decoder.sv | 122 ++++++++++++
 tb/tb_quad_decoder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_decoder_pkg.sv
// Shared constants and types for the rotary-encoder quadrature decoder.
// Gray states are encoded as {A, B}.
package quad_decoder_pkg;

    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_10 = 2'b10;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_01 = 2'b01;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } seq_state_t;

    function automatic logic [1:0] gray_cw_next(input logic [1:0] s);
        case (s)
            QS_00:   gray_cw_next = QS_10;
            QS_10:   gray_cw_next = QS_11;
            QS_11:   gray_cw_next = QS_01;
            default: gray_cw_next = QS_00;
        endcase
    endfunction

    function automatic logic [1:0] gray_ccw_next(input logic [1:0] s);
        case (s)
            QS_00:   gray_ccw_next = QS_01;
            QS_01:   gray_ccw_next = QS_11;
            QS_11:   gray_ccw_next = QS_10;
            default: gray_ccw_next = QS_00;
        endcase
    endfunction

endpackage

// File: rtl/quad_decoder_debounce.sv
// One encoder channel: 2-FF synchronizer followed by a stable-count debounce filter.
// The filtered value flips after DEB_CYCLES consecutive cycles of disagreement.
module quad_debounce #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);
    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            filt   <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (sync_2 == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                filt <= sync_2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Rotary-encoder quadrature decoder: phase tracking on the debounced A/B pair,
// one rot strobe per full detent, wrapping position count and error pulse.
//
// state | meaning
// IDLE  | waiting for a detected step; accepts it and updates dir/pos
// SETUP | dir/pos settled; rot rises on the next edge
// HIGH  | rot held high for ROT_HIGH_CYCLES
// LOW   | mandatory low cycle before the next step can be accepted
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int DEB_CYCLES      = 1000,
    parameter int ROT_HIGH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rot_a,
    input  logic       rot_b,
    output logic       rot,
    output logic       dir,
    output logic [7:0] pos,
    output logic       err
);
    localparam int HW = (ROT_HIGH_CYCLES > 1) ? $clog2(ROT_HIGH_CYCLES) : 1;

    logic              filt_a;
    logic              filt_b;
    logic [1:0]        ab_f;
    logic [1:0]        ab_q;
    logic signed [3:0] phase;
    logic signed [3:0] phase_nxt;
    logic              cw_move;
    logic              ccw_move;
    logic              bad_move;
    logic              step;
    logic              step_dir;
    seq_state_t        seq;
    logic [HW-1:0]     hcnt;

    quad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (rot_a),
        .filt  (filt_a)
    );

    quad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (rot_b),
        .filt  (filt_b)
    );

    assign ab_f = {filt_a, filt_b};

    // Accumulator saturates at +/-4 so a desynchronised phase after an
    // illegal jump cannot wrap the 4-bit signed range.
    always_comb begin
        cw_move   = (ab_f != ab_q) && (ab_f == gray_cw_next(ab_q));
        ccw_move  = (ab_f != ab_q) && (ab_f == gray_ccw_next(ab_q));
        bad_move  = (ab_f != ab_q) && !cw_move && !ccw_move;
        phase_nxt = phase;
        if (cw_move && (phase != 4'sd4))
            phase_nxt = phase + 4'sd1;
        if (ccw_move && (phase != -4'sd4))
            phase_nxt = phase - 4'sd1;
        step     = (cw_move || ccw_move) && (ab_f == QS_00) &&
                   ((phase_nxt == 4'sd4) || (phase_nxt == -4'sd4));
        step_dir = cw_move ? DIR_CW : DIR_CCW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_q  <= QS_00;
            phase <= 4'sd0;
            seq   <= IDLE;
            hcnt  <= '0;
            rot   <= 1'b0;
            dir   <= DIR_CW;
            pos   <= 8'd0;
            err   <= 1'b0;
        end else begin
            ab_q <= ab_f;
            err  <= bad_move || (step && (seq != IDLE));
            if (bad_move || step)
                phase <= 4'sd0;
            else
                phase <= phase_nxt;

            case (seq)
                IDLE: begin
                    if (step) begin
                        dir <= step_dir;
                        pos <= (step_dir == DIR_CW) ? pos + 8'd1 : pos - 8'd1;
                        seq <= SETUP;
                    end
                end
                SETUP: begin
                    rot  <= 1'b1;
                    hcnt <= HW'(ROT_HIGH_CYCLES - 1);
                    seq  <= HIGH;
                end
                HIGH: begin
                    if (hcnt == '0) begin
                        rot <= 1'b0;
                        seq <= LOW;
                    end else begin
                        hcnt <= hcnt - 1'b1;
                    end
                end
                LOW: begin
                    seq <= IDLE;
                end
                default: begin
                    rot <= 1'b0;
                    seq <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder with DEB_CYCLES=4, ROT_HIGH_CYCLES=2.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rot_a = 1'b0;
    logic       rot_b = 1'b0;
    logic       rot;
    logic       dir;
    logic [7:0] pos;
    logic       err;

    int checks = 0;
    int failures = 0;

    int   pulse_cnt = 0;
    int   err_cycles = 0;
    int   hi_run = 0;
    int   last_hi = 0;
    logic dir_at_rise = 1'b0;
    logic rot_prev = 1'b0;

    quad_decoder #(.DEB_CYCLES(4), .ROT_HIGH_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rot_a (rot_a),
        .rot_b (rot_b),
        .rot   (rot),
        .dir   (dir),
        .pos   (pos),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Passive observer: counts rot pulses, their width, dir at rise, err cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            rot_prev = 1'b0;
            hi_run   = 0;
        end else begin
            if (rot && !rot_prev) begin
                pulse_cnt++;
                dir_at_rise = dir;
            end
            if (rot)
                hi_run++;
            else if (rot_prev) begin
                last_hi = hi_run;
                hi_run  = 0;
            end
            if (err)
                err_cycles++;
            rot_prev = rot;
        end
    end

    task automatic hold_ab(input logic [1:0] ab, input int n);
        rot_a = ab[1];
        rot_b = ab[0];
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic detent(input bit cw);
        if (cw) begin
            hold_ab(2'b10, 20);
            hold_ab(2'b11, 20);
            hold_ab(2'b01, 20);
        end else begin
            hold_ab(2'b01, 20);
            hold_ab(2'b11, 20);
            hold_ab(2'b10, 20);
        end
        hold_ab(2'b00, 20);
    endtask

    task automatic do_reset();
        rot_a = 1'b0;
        rot_b = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rot !== 1'b0 || dir !== 1'b1 || pos !== 8'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values rot=%b dir=%b pos=%0d err=%b want rot=0 dir=1 pos=0 err=0",
                     rot, dir, pos, err);
        end
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rot !== 1'b0 || dir !== 1'b1 || pos !== 8'd0 || err !== 1'b0) begin
                failures++;
                $display("FAIL idle_cycle_%0d rot=%b dir=%b pos=%0d err=%b want 0/1/0/0",
                         i, rot, dir, pos, err);
            end
        end
    endtask

    task automatic test_cw_single();
        int p0;
        int pos_edge;
        int rot_edge;
        p0 = pulse_cnt;
        pos_edge = 0;
        rot_edge = 0;
        hold_ab(2'b10, 20);
        hold_ab(2'b11, 20);
        hold_ab(2'b01, 20);
        rot_a = 1'b0;
        rot_b = 1'b0;
        // Drive change: sampled on edge 1, filtered on edge 6, dir/pos on 7, rot on 8.
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (pos_edge == 0 && pos == 8'd1) pos_edge = n;
            if (rot_edge == 0 && rot === 1'b1) rot_edge = n;
        end
        checks++;
        if (pos_edge != 7) begin
            failures++;
            $display("FAIL cw_pos_edge got=%0d want=7", pos_edge);
        end
        checks++;
        if (rot_edge != 8) begin
            failures++;
            $display("FAIL cw_rot_rise_edge got=%0d want=8", rot_edge);
        end
        checks++;
        if (pulse_cnt - p0 != 1) begin
            failures++;
            $display("FAIL cw_pulse_count got=%0d want=1", pulse_cnt - p0);
        end
        checks++;
        if (dir_at_rise !== 1'b1) begin
            failures++;
            $display("FAIL cw_dir_at_rise got=%b want=1", dir_at_rise);
        end
        checks++;
        if (last_hi != 2) begin
            failures++;
            $display("FAIL cw_pulse_width got=%0d want=2", last_hi);
        end
        checks++;
        if (pos !== 8'd1) begin
            failures++;
            $display("FAIL cw_pos got=%0d want=1", pos);
        end
    endtask

    task automatic test_ccw_wrap();
        logic [7:0] exp_pos [3];
        int p0;
        exp_pos = '{8'd0, 8'd255, 8'd254};
        for (int k = 0; k < 3; k++) begin
            p0 = pulse_cnt;
            detent(1'b0);
            checks++;
            if (pulse_cnt - p0 != 1) begin
                failures++;
                $display("FAIL ccw_%0d_pulse_count got=%0d want=1", k, pulse_cnt - p0);
            end
            checks++;
            if (dir_at_rise !== 1'b0 || dir !== 1'b0) begin
                failures++;
                $display("FAIL ccw_%0d_dir got=%b/%b want=0", k, dir_at_rise, dir);
            end
            checks++;
            if (pos !== exp_pos[k]) begin
                failures++;
                $display("FAIL ccw_%0d_pos got=%0d want=%0d", k, pos, exp_pos[k]);
            end
            checks++;
            if (last_hi != 2 || rot !== 1'b0) begin
                failures++;
                $display("FAIL ccw_%0d_pulse_shape width=%0d rot=%b want width=2 rot=0",
                         k, last_hi, rot);
            end
        end
    endtask

    task automatic test_partial();
        int p0;
        int e0;
        p0 = pulse_cnt;
        e0 = err_cycles;
        hold_ab(2'b10, 20);
        hold_ab(2'b11, 20);
        hold_ab(2'b10, 20);
        hold_ab(2'b00, 20);
        checks++;
        if (pulse_cnt != p0 || pos !== 8'd254) begin
            failures++;
            $display("FAIL partial_no_step pulses=%0d pos=%0d want pulses=0 pos=254",
                     pulse_cnt - p0, pos);
        end
        checks++;
        if (err_cycles != e0) begin
            failures++;
            $display("FAIL partial_err got=%0d want=0", err_cycles - e0);
        end
    endtask

    task automatic test_bounce();
        int p0;
        int e0;
        p0 = pulse_cnt;
        e0 = err_cycles;
        hold_ab(2'b10, 8);
        hold_ab(2'b00, 2);
        hold_ab(2'b10, 10);
        hold_ab(2'b11, 20);
        hold_ab(2'b01, 8);
        hold_ab(2'b11, 2);
        hold_ab(2'b01, 10);
        hold_ab(2'b00, 20);
        checks++;
        if (pulse_cnt - p0 != 1 || dir_at_rise !== 1'b1) begin
            failures++;
            $display("FAIL bounce_step pulses=%0d dir=%b want pulses=1 dir=1",
                     pulse_cnt - p0, dir_at_rise);
        end
        checks++;
        if (pos !== 8'd255 || err_cycles != e0) begin
            failures++;
            $display("FAIL bounce_pos_err pos=%0d err=%0d want pos=255 err=0",
                     pos, err_cycles - e0);
        end
    endtask

    task automatic test_illegal_jump();
        int p0;
        int e0;
        p0 = pulse_cnt;
        e0 = err_cycles;
        hold_ab(2'b11, 20);
        checks++;
        if (err_cycles - e0 != 1) begin
            failures++;
            $display("FAIL jump_err_cycles got=%0d want=1", err_cycles - e0);
        end
        hold_ab(2'b01, 20);
        hold_ab(2'b00, 20);
        checks++;
        if (pulse_cnt != p0 || pos !== 8'd255) begin
            failures++;
            $display("FAIL jump_no_step pulses=%0d pos=%0d want pulses=0 pos=255",
                     pulse_cnt - p0, pos);
        end
    endtask

    task automatic test_reset_during_high();
        int p0;
        bit seen;
        do_reset();
        hold_ab(2'b10, 20);
        hold_ab(2'b11, 20);
        hold_ab(2'b01, 20);
        rot_a = 1'b0;
        rot_b = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (rot === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rst_high_wait rot never rose within 30 cycles got=0 want=1");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rot !== 1'b0 || pos !== 8'd0 || dir !== 1'b1) begin
            failures++;
            $display("FAIL rst_high_abort rot=%b pos=%0d dir=%b want rot=0 pos=0 dir=1",
                     rot, pos, dir);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        hold_ab(2'b00, 20);
        p0 = pulse_cnt;
        detent(1'b1);
        checks++;
        if (pos !== 8'd1 || pulse_cnt - p0 != 1) begin
            failures++;
            $display("FAIL rst_high_recover pos=%0d pulses=%0d want pos=1 pulses=1",
                     pos, pulse_cnt - p0);
        end
    endtask

    initial begin
        test_reset();
        test_cw_single();
        test_ccw_wrap();
        test_partial();
        test_bounce();
        test_illegal_jump();
        test_reset_during_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
